// File: rtl/rv32i_reg_scoreboard_pkg.sv
// rv32i_reg_scoreboard_pkg: shared register-file geometry for the RAW scoreboard
package rv32i_reg_scoreboard_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t X0 = '0;
endpackage

// File: rtl/rv32i_reg_scoreboard_if.sv
// rv32i_reg_scoreboard_if: decode/issue/writeback bundle between pipeline and scoreboard
interface rv32i_reg_scoreboard_if;
  import rv32i_reg_scoreboard_pkg::*;
  reg_addr_t             i_rs1_addr;
  reg_addr_t             i_rs2_addr;
  logic                  i_rs1_used;
  logic                  i_rs2_used;
  logic                  i_issue;
  reg_addr_t             i_issue_rd;
  logic                  i_issue_wr;
  logic                  i_wb_valid;
  reg_addr_t             i_wb_rd;
  logic                  i_flush;
  logic                  o_stall;
  logic [NUM_REGS-1:0]   o_pending;
  logic                  o_underflow;
  logic [31:0]           o_stall_cycles;
  modport master (
    output i_rs1_addr, i_rs2_addr, i_rs1_used, i_rs2_used, i_issue, i_issue_rd,
           i_issue_wr, i_wb_valid, i_wb_rd, i_flush,
    input  o_stall, o_pending, o_underflow, o_stall_cycles
  );
  modport slave (
    input  i_rs1_addr, i_rs2_addr, i_rs1_used, i_rs2_used, i_issue, i_issue_rd,
           i_issue_wr, i_wb_valid, i_wb_rd, i_flush,
    output o_stall, o_pending, o_underflow, o_stall_cycles
  );
endinterface

// File: rtl/rv32i_sb_counter.sv
// rv32i_sb_counter: per-register in-flight write counter, never wraps, flags decrement at zero
module rv32i_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear wins; inc and dec together cancel; saturate at both ends
  always_comb cnt_d = i_clr ? '0
                    : (i_inc && !i_dec && cnt_q != MAX) ? cnt_q + CNT_W'(1)
                    : (i_dec && !i_inc && cnt_q != '0)  ? cnt_q - CNT_W'(1)
                    : cnt_q;
  // counter state
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign o_cnt       = cnt_q;
  assign o_underflow = i_dec && !i_inc && cnt_q == '0;
endmodule

// File: rtl/rv32i_reg_scoreboard.sv
// rv32i_reg_scoreboard: RAW/WAW stall generation from per-register pending write counts
module rv32i_reg_scoreboard
  import rv32i_reg_scoreboard_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  rv32i_reg_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] uf_vec;
  logic [NUM_REGS-1:0] pend;
  logic                rs1_busy, rs2_busy, waw_full, inc;
  logic                uf_q, uf_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  assign cnt[0]    = '0;
  assign uf_vec[0] = 1'b0;
  assign pend[0]   = 1'b0;
  // a source whose final pending write lands this cycle reads new data via regfile bypass
  assign rs1_busy = cnt[sb.i_rs1_addr] != '0 &&
                    !(BYPASS != 0 && sb.i_wb_valid && sb.i_wb_rd == sb.i_rs1_addr &&
                      cnt[sb.i_rs1_addr] == CNT_W'(1));
  assign rs2_busy = cnt[sb.i_rs2_addr] != '0 &&
                    !(BYPASS != 0 && sb.i_wb_valid && sb.i_wb_rd == sb.i_rs2_addr &&
                      cnt[sb.i_rs2_addr] == CNT_W'(1));
  assign waw_full = sb.i_issue_wr && sb.i_issue_rd != X0 && cnt[sb.i_issue_rd] == MAX;
  assign sb.o_stall = (sb.i_rs1_used && rs1_busy) || (sb.i_rs2_used && rs2_busy) || waw_full;
  assign inc = sb.i_issue && !sb.o_stall && sb.i_issue_wr && sb.i_issue_rd != X0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    rv32i_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_inc       (inc && sb.i_issue_rd == REG_ADDR_W'(g)),
      .i_dec       (sb.i_wb_valid && sb.i_wb_rd == REG_ADDR_W'(g)),
      .i_clr       (sb.i_flush),
      .o_cnt       (cnt[g]),
      .o_underflow (uf_vec[g])
    );
    assign pend[g] = cnt[g] != '0;
  end
  assign sb.o_pending = pend;
  // sticky underflow and saturating stall-cycle counter
  always_comb begin
    uf_d        = uf_q || (|uf_vec);
    stall_cnt_d = (sb.o_stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  // error and performance state
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      uf_q        <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      uf_q        <= uf_d;
      stall_cnt_q <= stall_cnt_d;
    end
  assign sb.o_underflow    = uf_q;
  assign sb.o_stall_cycles = stall_cnt_q;
endmodule
